// File: rtl/epcs_rope_responder_if.sv
// Rope-fetch port of the EPCS flash emulator: AGC serial pins plus the rope memory read port.
// The master side is the AGC together with the rope memory; the slave side is the responder.
interface epcs_rope_responder_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  EPCS_DCLK;
  logic                  EPCS_CSN;
  logic                  EPCS_ASDI;
  logic                  EPCS_DATA;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic                  MEM_RD;
  logic [7:0]            MEM_RDATA;
  logic                  CMD_ERR;
  logic                  BUSY;

  modport master (
    output EPCS_DCLK, EPCS_CSN, EPCS_ASDI, MEM_RDATA,
    input  EPCS_DATA, MEM_ADDR, MEM_RD, CMD_ERR, BUSY
  );

  modport slave (
    input  EPCS_DCLK, EPCS_CSN, EPCS_ASDI, MEM_RDATA,
    output EPCS_DATA, MEM_ADDR, MEM_RD, CMD_ERR, BUSY
  );
endinterface

// File: rtl/epcs_rope_responder.sv
// EPCS flash emulator: decodes READ / READ STATUS from the AGC serial port and streams
// rope bytes from a synchronous on-chip memory with a two-byte prefetch.
module epcs_rope_responder #(
  parameter int         ADDR_WIDTH  = 17,
  parameter logic [7:0] STATUS_BYTE = 8'h00
) (
  input logic                  SIM_CLK,
  input logic                  SIM_RST,
  epcs_rope_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_STATUS = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  localparam logic [7:0]            CMD_READ = 8'h03;
  localparam logic [7:0]            CMD_RDSR = 8'h05;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  state_t                state_next;
  logic [1:0]            dclk_ff;
  logic [1:0]            csn_ff;
  logic [1:0]            asdi_ff;
  logic                  dclk_last;
  logic                  armed;
  logic                  dclk;
  logic                  csn;
  logic                  asdi;
  logic                  rise;
  logic                  fall;
  logic                  cmd_done;
  logic [7:0]            cmd_byte;
  logic [4:0]            bit_cnt;
  logic [ADDR_WIDTH-1:0] shift_in;
  logic [2:0]            pf_phase;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            shift_out;
  logic [7:0]            next_byte;
  logic                  first_byte;
  logic                  rd_valid;
  logic                  busy_next;
  logic                  cmd_err_next;
  logic                  epcs_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  cmd_err;
  logic                  busy;

  // CSN synchronizer resets low and 'armed' stays clear until CSN is seen high, so a
  // frame already running at reset release is ignored rather than decoded mid-stream.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      dclk_ff   <= 2'b00;
      csn_ff    <= 2'b00;
      asdi_ff   <= 2'b00;
      dclk_last <= 1'b0;
      armed     <= 1'b0;
    end else begin
      dclk_ff   <= {dclk_ff[0], bus.EPCS_DCLK};
      csn_ff    <= {csn_ff[0], bus.EPCS_CSN};
      asdi_ff   <= {asdi_ff[0], bus.EPCS_ASDI};
      dclk_last <= dclk_ff[1];
      armed     <= armed | csn_ff[1];
    end
  end

  assign dclk     = dclk_ff[1];
  assign csn      = csn_ff[1];
  assign asdi     = asdi_ff[1];
  assign rise     = dclk & ~dclk_last & ~csn;
  assign fall     = ~dclk & dclk_last & ~csn;
  assign cmd_byte = {shift_in[6:0], asdi};
  assign cmd_done = (state == ST_CMD) && rise && (bit_cnt == 5'd7);

  // State register.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; CSN high returns to IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (csn) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = armed ? ST_CMD : ST_IGNORE;
        ST_CMD: begin
          if (!cmd_done) begin
            state_next = ST_CMD;
          end else if (cmd_byte == CMD_READ) begin
            state_next = ST_ADDR;
          end else if (cmd_byte == CMD_RDSR) begin
            state_next = ST_STATUS;
          end else begin
            state_next = ST_IGNORE;
          end
        end
        ST_ADDR:   state_next = (pf_phase == 3'd5) ? ST_DATA : ST_ADDR;
        ST_DATA:   state_next = ST_DATA;
        ST_STATUS: state_next = ST_STATUS;
        ST_IGNORE: state_next = ST_IGNORE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Status outputs derived from the upcoming state.
  always_comb begin
    busy_next    = 1'b0;
    cmd_err_next = 1'b0;
    case (state_next)
      ST_CMD, ST_ADDR, ST_DATA, ST_STATUS: busy_next = 1'b1;
      default:                             busy_next = 1'b0;
    endcase
    if (cmd_done && (cmd_byte != CMD_READ) && (cmd_byte != CMD_RDSR)) begin
      cmd_err_next = 1'b1;
    end else begin
      cmd_err_next = 1'b0;
    end
  end

  // Serial shifting, prefetch sequencing (read, wait, capture+read, wait, capture) and refill.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      bit_cnt    <= 5'd0;
      shift_in   <= {ADDR_WIDTH{1'b0}};
      pf_phase   <= 3'd0;
      ptr        <= {ADDR_WIDTH{1'b0}};
      shift_out  <= 8'h00;
      next_byte  <= 8'h00;
      first_byte <= 1'b0;
      rd_valid   <= 1'b0;
      epcs_data  <= 1'b0;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      mem_rd     <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      rd_valid <= mem_rd;
      busy     <= busy_next;
      cmd_err  <= cmd_err_next;
      if (csn) begin
        bit_cnt    <= 5'd0;
        pf_phase   <= 3'd0;
        first_byte <= 1'b0;
        epcs_data  <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (rise) begin
              shift_in <= {shift_in[ADDR_WIDTH-2:0], asdi};
              bit_cnt  <= cmd_done ? 5'd0 : bit_cnt + 5'd1;
              if (cmd_done) begin
                shift_out <= STATUS_BYTE;
              end
            end
          end
          ST_ADDR: begin
            if (pf_phase == 3'd0) begin
              if (rise) begin
                shift_in <= {shift_in[ADDR_WIDTH-2:0], asdi};
                bit_cnt  <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                pf_phase <= (bit_cnt == 5'd23) ? 3'd1 : 3'd0;
              end
            end else begin
              pf_phase <= pf_phase + 3'd1;
              case (pf_phase)
                3'd1: begin
                  ptr      <= shift_in;
                  mem_addr <= shift_in;
                  mem_rd   <= 1'b1;
                end
                3'd3: begin
                  shift_out <= bus.MEM_RDATA;
                  ptr       <= ptr + PTR_ONE;
                  mem_addr  <= ptr + PTR_ONE;
                  mem_rd    <= 1'b1;
                end
                3'd5: begin
                  next_byte  <= bus.MEM_RDATA;
                  first_byte <= 1'b1;
                  bit_cnt    <= 5'd0;
                  pf_phase   <= 3'd0;
                end
                default: ;
              endcase
            end
          end
          ST_DATA: begin
            if (fall) begin
              bit_cnt    <= {2'b00, bit_cnt[2:0] + 3'd1};
              first_byte <= 1'b0;
              if ((bit_cnt[2:0] == 3'd0) && !first_byte) begin
                epcs_data <= next_byte[7];
                shift_out <= {next_byte[6:0], 1'b0};
                ptr       <= ptr + PTR_ONE;
                mem_addr  <= ptr + PTR_ONE;
                mem_rd    <= 1'b1;
              end else begin
                epcs_data <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
              end
            end
            if (rd_valid) begin
              next_byte <= bus.MEM_RDATA;
            end
          end
          ST_STATUS: begin
            if (fall) begin
              epcs_data <= shift_out[7];
              shift_out <= {shift_out[6:0], shift_out[7]};
            end
          end
          ST_IDLE: begin
            bit_cnt   <= 5'd0;
            epcs_data <= 1'b0;
          end
          default: begin
            epcs_data <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.EPCS_DATA = epcs_data;
  assign bus.MEM_ADDR  = mem_addr;
  assign bus.MEM_RD    = mem_rd;
  assign bus.CMD_ERR   = cmd_err;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_epcs_rope_responder.sv
// Bench for epcs_rope_responder: two instances (STATUS_BYTE 00 and C3) driven in lockstep,
// checked against a byte-stream model of the rope memory and the expected read addresses.
module tb_epcs_rope_responder;
  localparam int AW = 17;
  localparam int H  = 7;

  logic clk = 1'b0;
  logic rst;
  logic dclk;
  logic csn;
  logic asdi;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [0:(1<<AW)-1];

  logic [AW-1:0] rq0[$];
  logic [AW-1:0] rq1[$];
  int   err0 = 0;
  int   err1 = 0;
  int   wide = 0;
  logic rd0_d = 1'b0, rd1_d = 1'b0, ce0_d = 1'b0, ce1_d = 1'b0;
  int   r0, r1;

  epcs_rope_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
  epcs_rope_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

  epcs_rope_responder #(.ADDR_WIDTH(AW), .STATUS_BYTE(8'h00)) dut0 (
    .SIM_CLK(clk), .SIM_RST(rst), .bus(bus0));
  epcs_rope_responder #(.ADDR_WIDTH(AW), .STATUS_BYTE(8'hC3)) dut1 (
    .SIM_CLK(clk), .SIM_RST(rst), .bus(bus1));

  always #5 clk = ~clk;

  assign bus0.EPCS_DCLK = dclk;
  assign bus0.EPCS_CSN  = csn;
  assign bus0.EPCS_ASDI = asdi;
  assign bus1.EPCS_DCLK = dclk;
  assign bus1.EPCS_CSN  = csn;
  assign bus1.EPCS_ASDI = asdi;

  always @(posedge clk) begin
    if (bus0.MEM_RD) bus0.MEM_RDATA <= mem[bus0.MEM_ADDR];
    if (bus1.MEM_RD) bus1.MEM_RDATA <= mem[bus1.MEM_ADDR];
  end

  always @(negedge clk) begin
    if (bus0.MEM_RD) rq0.push_back(bus0.MEM_ADDR);
    if (bus1.MEM_RD) rq1.push_back(bus1.MEM_ADDR);
    if (bus0.CMD_ERR) err0++;
    if (bus1.CMD_ERR) err1++;
    if ((bus0.MEM_RD && rd0_d) || (bus1.MEM_RD && rd1_d) ||
        (bus0.CMD_ERR && ce0_d) || (bus1.CMD_ERR && ce1_d)) wide++;
    rd0_d = bus0.MEM_RD;
    rd1_d = bus1.MEM_RD;
    ce0_d = bus0.CMD_ERR;
    ce1_d = bus1.CMD_ERR;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial bit i of a frame: rope bytes from addr upward, or the repeating status byte.
  function automatic logic exp_bit(input logic [7:0] status, input logic [7:0] cmd,
                                   input logic [23:0] addr, input int i);
    logic [7:0] b;
    if (cmd == 8'h03) b = mem[(int'(addr) + i / 8) % (1 << AW)];
    else if (cmd == 8'h05) b = status;
    else b = 8'h00;
    return b[7 - (i % 8)];
  endfunction

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      dclk = 1'b0;
      asdi = v[i];
      tick(H);
      dclk = 1'b1;
      tick(H);
    end
  endtask

  task automatic read_check(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                            input int n);
    logic busy_exp;
    busy_exp = (cmd == 8'h03) || (cmd == 8'h05);
    for (int i = 0; i < n; i++) begin
      dclk = 1'b0;
      tick(H);
      chk($sformatf("%s_b%0d_d0", tag, i), bus0.EPCS_DATA, exp_bit(8'h00, cmd, addr, i));
      chk($sformatf("%s_b%0d_d1", tag, i), bus1.EPCS_DATA, exp_bit(8'hC3, cmd, addr, i));
      if (i == 0) begin
        chk({tag, "_busy0"}, bus0.BUSY, busy_exp);
        chk({tag, "_busy1"}, bus1.BUSY, busy_exp);
      end
      dclk = 1'b1;
      tick(H);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] cmd, input logic [23:0] addr,
                       input int n);
    int s0, s1, e0, e1, nrd;
    logic [31:0] got;
    s0 = rq0.size();
    s1 = rq1.size();
    e0 = err0;
    e1 = err1;
    csn = 1'b0;
    tick(4);
    chk({tag, "_busy_cmd"}, bus0.BUSY, 1'b1);
    send_bits({24'h0, cmd}, 8);
    if (cmd == 8'h03) send_bits({8'h0, addr}, 24);
    read_check(tag, cmd, addr, n);
    csn = 1'b1;
    tick(4);
    dclk = 1'b0;
    tick(4);
    chk({tag, "_busy_end"}, bus0.BUSY | bus1.BUSY, 1'b0);
    nrd = (cmd == 8'h03) ? 2 + (n - 1) / 8 : 0;
    chk({tag, "_nrd0"}, rq0.size() - s0, nrd);
    chk({tag, "_nrd1"}, rq1.size() - s1, nrd);
    for (int k = 0; k < nrd; k++) begin
      got = (s0 + k < rq0.size()) ? 32'(rq0[s0 + k]) : 32'hDEADBEEF;
      chk($sformatf("%s_rdaddr%0d", tag, k), got, (int'(addr) + k) % (1 << AW));
    end
    chk({tag, "_cmderr0"}, err0 - e0, ((cmd != 8'h03) && (cmd != 8'h05)) ? 1 : 0);
    chk({tag, "_cmderr1"}, err1 - e1, ((cmd != 8'h03) && (cmd != 8'h05)) ? 1 : 0);
  endtask

  initial begin
    rst  = 1'b1;
    dclk = 1'b0;
    csn  = 1'b1;
    asdi = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[17'h00010] = 8'hA5;
    mem[17'h00011] = 8'h3C;
    mem[17'h1FFFF] = 8'h81;
    mem[17'h00000] = 8'h7E;
    mem[17'h00300] = 8'hFF;
    mem[17'h00301] = 8'hFF;
    tick(2);
    chk("rst_data", bus0.EPCS_DATA, 1'b0);
    chk("rst_addr", bus0.MEM_ADDR, 0);
    chk("rst_rd", bus0.MEM_RD, 1'b0);
    chk("rst_cmderr", bus0.CMD_ERR, 1'b0);
    chk("rst_busy", bus0.BUSY | bus1.BUSY, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("idle_busy", bus0.BUSY, 1'b0);

    frame("read10", 8'h03, 24'h000010, 16);
    frame("wrap", 8'h03, 24'h01FFFF, 16);
    frame("status", 8'h05, 24'h000000, 16);
    frame("badcmd", 8'h9F, 24'h000000, 16);
    frame("after_bad", 8'h03, 24'h000010, 16);

    // Aborted frame after 12 address bits, then a normal read.
    r0 = rq0.size();
    csn = 1'b0;
    tick(4);
    send_bits(32'h03, 8);
    send_bits(32'h000, 12);
    csn = 1'b1;
    tick(4);
    dclk = 1'b0;
    tick(4);
    chk("abort_nrd", rq0.size() - r0, 0);
    chk("abort_busy", bus0.BUSY, 1'b0);
    frame("read20", 8'h03, 24'h000020, 16);

    // Reset in the middle of a data stream with CSN held low.
    csn = 1'b0;
    tick(4);
    send_bits(32'h03, 8);
    send_bits(32'h000300, 24);
    read_check("pre_rst", 8'h03, 24'h000300, 4);
    rst = 1'b1;
    #1;
    chk("midrst_data", bus0.EPCS_DATA, 1'b0);
    chk("midrst_addr", bus0.MEM_ADDR, 0);
    chk("midrst_rd", bus0.MEM_RD, 1'b0);
    chk("midrst_busy", bus0.BUSY, 1'b0);
    tick(2);
    rst = 1'b0;
    r0 = rq0.size();
    r1 = rq1.size();
    for (int i = 0; i < 16; i++) begin
      dclk = 1'b0;
      tick(H);
      chk($sformatf("postrst_b%0d_data", i), bus0.EPCS_DATA | bus1.EPCS_DATA, 1'b0);
      chk($sformatf("postrst_b%0d_busy", i), bus0.BUSY | bus1.BUSY, 1'b0);
      dclk = 1'b1;
      tick(H);
    end
    chk("postrst_nrd0", rq0.size() - r0, 0);
    chk("postrst_nrd1", rq1.size() - r1, 0);
    csn = 1'b1;
    tick(4);
    dclk = 1'b0;
    tick(4);
    frame("post_rst", 8'h03, 24'h000301, 16);

    for (int t = 0; t < 6; t++) begin
      frame($sformatf("rand%0d", t), 8'h03, 24'($urandom), $urandom_range(8, 26));
    end
    frame("status2", 8'h05, 24'h000000, 12);

    chk("pulse_width", wide, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
